sm_step_receiver: RTL

Receiving end of the stepper-motor step/enable interface. Qualifies incoming step pulses against glitches and over-speed, tracks the signed motor position, and drives the four coil-phase outputs of a unipolar stepper in full- or half-step mode. Sits between the step-pulse generator (`drv_step`/`drv_SM` source) and the coil driver pins.

---
 rtl/sm_step_receiver.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sm_step_receiver.sv
// sm_step_receiver: receiving end of the stepper step/enable interface.
// Synchronizes step/dir/enable, qualifies step pulses against glitches and
// over-speed, tracks a signed position and drives the unipolar coil phases.
//
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   step_in       - step pulse (asynchronous)
//   dir_in        - direction, 1 = forward (+1), 0 = reverse (-1) (asynchronous)
//   en_in         - motor enable (asynchronous)
//   clr_pos       - synchronous single-cycle position clear
//   err_clr       - synchronous clear of err_fast
//   pos           - signed position count, wraps modulo 2^WIDTH_POS
//   coil          - coil drive {A,B,C,D}, all off while disabled
//   step_ack      - one-cycle pulse per accepted step
//   err_fast      - sticky over-speed rejection flag
module sm_step_receiver #(
  parameter int unsigned WIDTH_POS  = 16,
  parameter int unsigned MIN_HIGH   = 3,
  parameter int unsigned MIN_PERIOD = 50,
  parameter int unsigned HALF_STEP  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic                 en_in,
  input  logic                 clr_pos,
  input  logic                 err_clr,
  output logic [WIDTH_POS-1:0] pos,
  output logic [3:0]           coil,
  output logic                 step_ack,
  output logic                 err_fast
);

  localparam int unsigned HCNT_W = $clog2(MIN_HIGH + 1);
  localparam int unsigned PCNT_W = $clog2(MIN_PERIOD + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNT    = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  // Full-step walks only the odd (two-phase-on) entries of the table
  localparam logic [2:0] PH_RESET = (HALF_STEP != 0) ? 3'd0 : 3'd1;
  localparam logic [2:0] PH_STEP  = (HALF_STEP != 0) ? 3'd1 : 3'd2;

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(MIN_PERIOD);

  logic step_s1_q, step_s2_q;
  logic dir_s1_q, dir_s2_q;
  logic en_s1_q, en_s2_q;

  logic [1:0]           state_q, state_d;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
  logic [2:0]           ph_q, ph_d;
  logic [WIDTH_POS-1:0] pos_q, pos_d;
  logic [3:0]           coil_q, coil_d;
  logic                 step_ack_q, step_ack_d;
  logic                 err_fast_q, err_fast_d;

  logic s, d, e;
  logic qualify, accept, reject;

  function automatic logic [3:0] coil_of(input logic [2:0] p);
    case (p)
      3'd0:    coil_of = 4'b1000;
      3'd1:    coil_of = 4'b1100;
      3'd2:    coil_of = 4'b0100;
      3'd3:    coil_of = 4'b0110;
      3'd4:    coil_of = 4'b0010;
      3'd5:    coil_of = 4'b0011;
      3'd6:    coil_of = 4'b0001;
      default: coil_of = 4'b1001;
    endcase
  endfunction

  // Two-stage synchronizers; step resets high so a level held through reset is not a step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1_q <= 1'b1;
      step_s2_q <= 1'b1;
      dir_s1_q  <= 1'b0;
      dir_s2_q  <= 1'b0;
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
    end else begin
      step_s1_q <= step_in;
      step_s2_q <= step_s1_q;
      dir_s1_q  <= dir_in;
      dir_s2_q  <= dir_s1_q;
      en_s1_q   <= en_in;
      en_s2_q   <= en_s1_q;
    end
  end

  assign s = step_s2_q;
  assign d = dir_s2_q;
  assign e = en_s2_q;

  // Qualifier FSM plus step bookkeeping; qualify fires on the MIN_HIGH-th high cycle
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    qualify    = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    pcnt_d     = pcnt_q;
    ph_d       = ph_q;
    pos_d      = pos_q;
    coil_d     = 4'b0000;
    step_ack_d = 1'b0;
    err_fast_d = err_fast_q;

    case (state_q)
      ST_IDLE: begin
        if (s) begin
          if (MIN_HIGH == 1) begin
            qualify = 1'b1;
            state_d = ST_WAIT_LOW;
          end else begin
            state_d = ST_COUNT;
            hcnt_d  = HCNT_W'(1);
          end
        end
      end
      ST_COUNT: begin
        if (!s) begin
          state_d = ST_IDLE;
        end else if (hcnt_q == HCNT_W'(MIN_HIGH - 1)) begin
          qualify = 1'b1;
          state_d = ST_WAIT_LOW;
        end else begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!s) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_LOW;
    endcase

    accept = qualify && e && (pcnt_q == PCNT_MAX);
    reject = qualify && e && (pcnt_q != PCNT_MAX);

    // Period counter holds on a rejected step so the rejection does not shorten the wait
    if (accept)                  pcnt_d = '0;
    else if (reject)             pcnt_d = pcnt_q;
    else if (pcnt_q != PCNT_MAX) pcnt_d = pcnt_q + PCNT_W'(1);

    if (accept) begin
      ph_d       = d ? (ph_q + PH_STEP) : (ph_q - PH_STEP);
      pos_d      = d ? (pos_q + WIDTH_POS'(1)) : (pos_q - WIDTH_POS'(1));
      step_ack_d = 1'b1;
    end

    if (clr_pos) pos_d = '0;

    if (reject)       err_fast_d = 1'b1;
    else if (err_clr) err_fast_d = 1'b0;

    if (e) coil_d = coil_of(ph_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WAIT_LOW;
      hcnt_q     <= '0;
      pcnt_q     <= PCNT_MAX;
      ph_q       <= PH_RESET;
      pos_q      <= '0;
      coil_q     <= 4'b0000;
      step_ack_q <= 1'b0;
      err_fast_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      pcnt_q     <= pcnt_d;
      ph_q       <= ph_d;
      pos_q      <= pos_d;
      coil_q     <= coil_d;
      step_ack_q <= step_ack_d;
      err_fast_q <= err_fast_d;
    end
  end

  assign pos      = pos_q;
  assign coil     = coil_q;
  assign step_ack = step_ack_q;
  assign err_fast = err_fast_q;

endmodule
